// File: rtl/hw_call_stack_pkg.sv
// Shared definitions for the hardware return-address stack.
package hw_call_stack_pkg;

  localparam int STACK_DEPTH = 16;
  localparam int STACK_SP_W  = 5;
  localparam int STACK_DW    = 8;

  // Pop request kind after resolving pop_1/pop_2 priority (pop_2 wins).
  // CMD_PUSH is carried separately as the push_stack strobe.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP1 = 2'd2,
    CMD_POP2 = 2'd3
  } stack_cmd_e;

endpackage

// File: rtl/hw_call_stack_regfile.sv
// Byte-wide storage array: one synchronous write port, two async read ports.
// Contents are never reset; the top module gates reads by the entry count.
module hw_call_stack_regfile
  import hw_call_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [STACK_DW-1:0] wdata,
  input  logic [AW-1:0]       raddr_a,
  input  logic [AW-1:0]       raddr_b,
  output logic [STACK_DW-1:0] rdata_a,
  output logic [STACK_DW-1:0] rdata_b
);

  logic [STACK_DW-1:0] mem_q [DEPTH];

  // Write port: single byte per cycle.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/hw_call_stack.sv
// Return-address stack: stack pointer, command decode, sticky error flags
// and gating of the two top-of-stack read ports.
//
// Command interface: push_stack / pop_1_stack / pop_2_stack are single-cycle
// strobes sampled on every rising clock edge; there is no back-pressure. A
// command that cannot be honoured is dropped in full and raises a sticky flag.
// The new top is visible combinationally in the cycle after the edge.
module hw_call_stack
  import hw_call_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int SP_W  = STACK_SP_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_stack,
  input  logic [STACK_DW-1:0] stack_in,
  input  logic                pop_1_stack,
  input  logic                pop_2_stack,
  input  logic                clr_err,
  output logic [STACK_DW-1:0] stack_out,
  output logic [STACK_DW-1:0] stack_out_2,
  output logic [SP_W-1:0]     depth,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow,
  output logic                proto_err
);

  localparam int AW = $clog2(DEPTH);

  logic [SP_W-1:0] sp_q, sp_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            proto_err_q, proto_err_d;

  stack_cmd_e      pop_cmd;
  logic            has_1, has_2, is_full;
  logic [AW-1:0]   addr_top, addr_m1, addr_m2;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [STACK_DW-1:0] rdata_a, rdata_b;

  assign has_1   = (sp_q >= SP_W'(1));
  assign has_2   = (sp_q >= SP_W'(2));
  assign is_full = (sp_q == SP_W'(DEPTH));

  // Only the low address bits matter; out-of-range values are gated below.
  assign addr_top = AW'(sp_q);
  assign addr_m1  = AW'(sp_q - SP_W'(1));
  assign addr_m2  = AW'(sp_q - SP_W'(2));

  // Resolve pop priority: pop_2 wins over pop_1.
  always_comb begin
    pop_cmd = CMD_NONE;
    if (pop_2_stack) begin
      pop_cmd = CMD_POP2;
    end else if (pop_1_stack) begin
      pop_cmd = CMD_POP1;
    end
  end

  // Next-state decode for sp, write port and sticky flags.
  always_comb begin
    sp_d        = sp_q;
    we          = 1'b0;
    waddr       = addr_top;
    overflow_d  = overflow_q  & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    proto_err_d = proto_err_q & ~clr_err;

    if (pop_1_stack && pop_2_stack) begin
      proto_err_d = 1'b1;
    end

    case (pop_cmd)
      CMD_NONE: begin
        if (push_stack) begin
          if (!is_full) begin
            we    = 1'b1;
            waddr = addr_top;
            sp_d  = sp_q + SP_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      CMD_POP1: begin
        if (has_1) begin
          if (push_stack) begin
            // Replace the top in place; net depth change is zero.
            we    = 1'b1;
            waddr = addr_m1;
          end else begin
            sp_d = sp_q - SP_W'(1);
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
      CMD_POP2: begin
        if (has_2) begin
          if (push_stack) begin
            // Drop two, push one: new top lands where the second byte was.
            we    = 1'b1;
            waddr = addr_m2;
            sp_d  = sp_q - SP_W'(1);
          end else begin
            sp_d = sp_q - SP_W'(2);
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // Reset dominates any command issued in the same cycle.
    if (reset) begin
      we = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  hw_call_stack_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clock   (clock),
    .we      (we),
    .waddr   (waddr),
    .wdata   (stack_in),
    .raddr_a (addr_m1),
    .raddr_b (addr_m2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign stack_out   = has_1 ? rdata_a : '0;
  assign stack_out_2 = has_2 ? rdata_b : '0;
  assign depth       = sp_q;
  assign empty       = (sp_q == '0);
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_hw_call_stack.sv
// Self-checking bench for hw_call_stack: a queue-based reference stack
// predicts every cycle's outputs into a scoreboard, plus directed checks.
module tb_hw_call_stack;

  localparam int DEPTH = 16;
  localparam int SP_W  = 5;
  localparam int EXP_W = SP_W + 8 + 8 + 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            push_stack = 1'b0;
  logic [7:0]      stack_in = 8'h00;
  logic            pop_1_stack = 1'b0;
  logic            pop_2_stack = 1'b0;
  logic            clr_err = 1'b0;
  logic [7:0]      stack_out;
  logic [7:0]      stack_out_2;
  logic [SP_W-1:0] depth;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;
  logic            proto_err;

  hw_call_stack #(
    .DEPTH (DEPTH),
    .SP_W  (SP_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .push_stack  (push_stack),
    .stack_in    (stack_in),
    .pop_1_stack (pop_1_stack),
    .pop_2_stack (pop_2_stack),
    .clr_err     (clr_err),
    .stack_out   (stack_out),
    .stack_out_2 (stack_out_2),
    .depth       (depth),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow),
    .proto_err   (proto_err)
  );

  // Clock generation.
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  // Reference model state.
  logic [7:0] m_stk[$];
  logic       m_ovf = 1'b0;
  logic       m_und = 1'b0;
  logic       m_pro = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic psh, input logic [7:0] din,
                            input logic p1, input logic p2,
                            input logic clr, input logic rst);
    int pop;
    if (rst) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_und = 1'b0;
      m_pro = 1'b0;
      return;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_und = 1'b0;
      m_pro = 1'b0;
    end
    if (p1 && p2) m_pro = 1'b1;
    pop = p2 ? 2 : (p1 ? 1 : 0);
    if (pop == 0) begin
      if (psh) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(din);
        else m_ovf = 1'b1;
      end
    end else if (pop == 1) begin
      if (m_stk.size() >= 1) begin
        if (psh) m_stk[m_stk.size()-1] = din;
        else void'(m_stk.pop_back());
      end else begin
        m_und = 1'b1;
      end
    end else begin
      if (m_stk.size() >= 2) begin
        void'(m_stk.pop_back());
        if (psh) m_stk[m_stk.size()-1] = din;
        else void'(m_stk.pop_back());
      end else begin
        m_und = 1'b1;
      end
    end
  endtask

  function automatic logic [EXP_W-1:0] model_vec();
    logic [SP_W-1:0] d;
    logic [7:0]      t1, t2;
    int              n;
    n  = m_stk.size();
    d  = SP_W'(n);
    t1 = (n >= 1) ? m_stk[n-1] : 8'h00;
    t2 = (n >= 2) ? m_stk[n-2] : 8'h00;
    return {d, t1, t2, (n == 0), (n == DEPTH), m_ovf, m_und, m_pro};
  endfunction

  task automatic check_outputs();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underrun", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("depth",       32'(depth),       32'(e[25:21]));
    check("stack_out",   32'(stack_out),   32'(e[20:13]));
    check("stack_out_2", 32'(stack_out_2), 32'(e[12:5]));
    check("empty",       32'(empty),       32'(e[4]));
    check("full",        32'(full),        32'(e[3]));
    check("overflow",    32'(overflow),    32'(e[2]));
    check("underflow",   32'(underflow),   32'(e[1]));
    check("proto_err",   32'(proto_err),   32'(e[0]));
  endtask

  // Drive one cycle of commands, predict, then compare after the edge.
  task automatic step(input logic psh, input logic [7:0] din,
                      input logic p1, input logic p2,
                      input logic clr, input logic rst);
    reset       = rst;
    push_stack  = psh;
    stack_in    = din;
    pop_1_stack = p1;
    pop_2_stack = p2;
    clr_err     = clr;
    model_step(psh, din, p1, p2, clr, rst);
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_push(input logic [7:0] din);
    step(1'b1, din, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    // Reset state.
    do_reset();
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_out",   32'(stack_out), 32'h00);

    // T1: two pushes then pop_2.
    do_push(8'hA5);
    do_push(8'h3C);
    check("t1_depth", 32'(depth), 32'd2);
    check("t1_top",   32'(stack_out), 32'h3C);
    check("t1_next",  32'(stack_out_2), 32'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_pop_depth", 32'(depth), 32'd0);
    check("t1_pop_empty", 32'(empty), 32'd1);
    check("t1_pop_out",   32'(stack_out), 32'h00);

    // T2: fill to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) do_push(8'(i));
    check("t2_full", 32'(full), 32'd1);
    check("t2_top",  32'(stack_out), 32'h0F);
    do_push(8'hFF);
    check("t2_ovf",   32'(overflow), 32'd1);
    check("t2_depth", 32'(depth), 32'd16);
    check("t2_top2",  32'(stack_out), 32'h0F);

    // T3: underflow on empty, partial pop_2 rejected, clear.
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_und", 32'(underflow), 32'd1);
    check("t3_depth0", 32'(depth), 32'd0);
    do_push(8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_und_sticky", 32'(underflow), 32'd1);
    check("t3_depth1", 32'(depth), 32'd1);
    check("t3_top", 32'(stack_out), 32'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_clr", 32'(underflow), 32'd0);

    // T4: push combined with pops.
    do_reset();
    do_push(8'hA5);
    do_push(8'h3C);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_depth_a", 32'(depth), 32'd2);
    check("t4_top_a",   32'(stack_out), 32'h77);
    check("t4_next_a",  32'(stack_out_2), 32'hA5);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_depth_b", 32'(depth), 32'd1);
    check("t4_top_b",   32'(stack_out), 32'h55);

    // T5: both pops together.
    do_reset();
    do_push(8'h01);
    do_push(8'h02);
    do_push(8'h03);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_proto", 32'(proto_err), 32'd1);
    check("t5_depth", 32'(depth), 32'd1);

    // Clear and new error in the same cycle leaves the flag set.
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_vs_set_proto", 32'(proto_err), 32'd1);

    // T6: reset with push active.
    do_reset();
    for (int i = 0; i < 5; i++) do_push(8'(8'h40 + i));
    check("t6_pre_depth", 32'(depth), 32'd5);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_depth", 32'(depth), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_out",   32'(stack_out), 32'h00);
    check("t6_flags", 32'({overflow, underflow, proto_err}), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    reset       = 1'b0;
    push_stack  = 1'b0;
    pop_1_stack = 1'b0;
    pop_2_stack = 1'b0;
    clr_err     = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
